// File: rtl/m26_rx_framer.sv
// Mimosa26 per-channel receive framer: checks frame structure, tags each 16-bit word
// into a 32-bit record and buffers it in a FIFO drained via valid/ready.
module m26_rx_framer #(
    parameter logic [7:0]  IDENTIFIER = 8'h20,
    parameter logic [3:0]  CHANNEL    = 4'd0,
    parameter int          DEPTH      = 16,
    parameter logic [15:0] MAX_LEN    = 16'd576
) (
    input  logic        CLK_RX,
    input  logic        RST_N,
    input  logic        WRITE,
    input  logic        FRAME_START,
    input  logic [15:0] DATA,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [31:0] OUT_DATA,
    output logic [15:0] FRAME_CNT,
    output logic [7:0]  ERR_CNT,
    output logic [7:0]  LOST_CNT,
    output logic        BUSY
);
    localparam int AW = $clog2(DEPTH);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] HDR  = 3'd1;
    localparam logic [2:0] FCNT = 3'd2;
    localparam logic [2:0] LEN  = 3'd3;
    localparam logic [2:0] DAT  = 3'd4;
    localparam logic [2:0] TRL  = 3'd5;

    logic [2:0]  state, state_nxt;
    logic [15:0] word_cnt, cnt_nxt;
    logic [15:0] len0, len0_nxt;
    logic        t0_ok, t0_ok_nxt;
    logic        err_inc, frame_inc;

    logic [31:0] mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        empty, full, pop, want_push, push_ok, drop;
    logic [31:0] push_word;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign OUT_VALID = !empty;
    assign OUT_DATA  = empty ? 32'd0 : mem[rd_ptr[AW-1:0]];
    assign pop       = OUT_VALID && OUT_READY;
    assign BUSY      = (state != IDLE);

    // A full FIFO still has room this cycle when the consumer pops its head.
    assign want_push = WRITE && (FRAME_START || state != IDLE);
    assign push_ok   = want_push && (!full || OUT_READY);
    assign drop      = want_push && !push_ok;
    assign push_word = {IDENTIFIER, CHANNEL, 3'b000, FRAME_START, DATA};

    // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latches).
    always_comb begin
        state_nxt = state;
        cnt_nxt   = word_cnt;
        len0_nxt  = len0;
        t0_ok_nxt = t0_ok;
        err_inc   = 1'b0;
        frame_inc = 1'b0;
        if (drop) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else if (WRITE && FRAME_START) begin
            // Restart and bad-H0 are one event: one error, one push.
            err_inc   = (state != IDLE) || (DATA[15:4] != 12'h555);
            state_nxt = (DATA[15:4] == 12'h555) ? HDR : IDLE;
            cnt_nxt   = '0;
        end else if (WRITE) begin
            cnt_nxt = word_cnt + 16'd1;
            case (state)
                HDR: begin
                    state_nxt = FCNT;
                    cnt_nxt   = '0;
                end
                FCNT: if (word_cnt == 16'd1) begin
                    state_nxt = LEN;
                    cnt_nxt   = '0;
                end
                LEN: begin
                    if (word_cnt == 16'd0) begin
                        len0_nxt = DATA;
                    end else begin
                        cnt_nxt = '0;
                        if (DATA != len0 || len0 > MAX_LEN) begin
                            err_inc   = 1'b1;
                            state_nxt = IDLE;
                        end else begin
                            state_nxt = (len0 == 16'd0) ? TRL : DAT;
                        end
                    end
                end
                DAT: if (word_cnt == len0 - 16'd1) begin
                    state_nxt = TRL;
                    cnt_nxt   = '0;
                end
                TRL: begin
                    if (word_cnt == 16'd0) begin
                        t0_ok_nxt = (DATA[15:4] == 12'hAAA);
                        err_inc   = (DATA[15:4] != 12'hAAA);
                    end else begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                        frame_inc = t0_ok;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge CLK_RX or negedge RST_N) begin
        if (!RST_N) begin
            state     <= IDLE;
            word_cnt  <= '0;
            len0      <= '0;
            t0_ok     <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            FRAME_CNT <= '0;
            ERR_CNT   <= '0;
            LOST_CNT  <= '0;
        end else begin
            state    <= state_nxt;
            word_cnt <= cnt_nxt;
            len0     <= len0_nxt;
            t0_ok    <= t0_ok_nxt;
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            if (frame_inc) FRAME_CNT <= FRAME_CNT + 16'd1;
            if (err_inc && ERR_CNT != 8'hFF) ERR_CNT <= ERR_CNT + 8'd1;
            if (drop && LOST_CNT != 8'hFF) LOST_CNT <= LOST_CNT + 8'd1;
        end
    end

    // NOTE: storage is not reset; the pointers alone define which entries are valid.
    always_ff @(posedge CLK_RX) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= push_word;
    end
endmodule

// File: tb/tb_m26_rx_framer.sv
// Testbench for m26_rx_framer: directed frame scenarios plus randomized frames,
// all compared cycle by cycle against a frame-position reference model.
module tb_m26_rx_framer;
    localparam int          DEPTH   = 16;
    localparam logic [15:0] MAX_LEN = 16'd576;

    logic        CLK_RX = 1'b0;
    logic        RST_N = 1'b0;
    logic        WRITE = 1'b0;
    logic        FRAME_START = 1'b0;
    logic [15:0] DATA = '0;
    logic        OUT_READY = 1'b0;
    logic        OUT_VALID;
    logic [31:0] OUT_DATA;
    logic [15:0] FRAME_CNT;
    logic [7:0]  ERR_CNT;
    logic [7:0]  LOST_CNT;
    logic        BUSY;

    m26_rx_framer #(.IDENTIFIER(8'h20), .CHANNEL(4'd0), .DEPTH(DEPTH), .MAX_LEN(MAX_LEN)) dut (
        .CLK_RX(CLK_RX), .RST_N(RST_N), .WRITE(WRITE), .FRAME_START(FRAME_START), .DATA(DATA),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA),
        .FRAME_CNT(FRAME_CNT), .ERR_CNT(ERR_CNT), .LOST_CNT(LOST_CNT), .BUSY(BUSY)
    );

    always #5 CLK_RX = ~CLK_RX;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: tracks position inside the frame rather than protocol states.
    logic [31:0] mq[$];
    logic [15:0] m_frame;
    int          m_err, m_lost, m_pos, m_len0;
    bit          m_in, m_t0_bad;

    function automatic void model_reset();
        mq.delete();
        m_frame = '0; m_err = 0; m_lost = 0;
        m_in = 1'b0; m_pos = 0; m_len0 = 0; m_t0_bad = 1'b0;
    endfunction

    function automatic void model_err();
        if (m_err < 255) m_err++;
    endfunction

    function automatic void model_apply(input bit w, input bit fs, input logic [15:0] d, input bit rdy);
        bit pop, blocked;
        pop     = rdy && (mq.size() > 0);
        blocked = (mq.size() == DEPTH) && !pop;
        if (pop) void'(mq.pop_front());
        if (!(w && (fs || m_in))) return;
        if (blocked) begin
            if (m_lost < 255) m_lost++;
            m_in = 1'b0;
            return;
        end
        mq.push_back({8'h20, 4'h0, 3'b000, fs, d});
        if (fs) begin
            if (m_in || d[15:4] != 12'h555) model_err();
            m_in  = (d[15:4] == 12'h555);
            m_pos = 1;
            return;
        end
        if (m_pos == 4) m_len0 = int'(d);
        else if (m_pos == 5) begin
            if (int'(d) != m_len0 || m_len0 > int'(MAX_LEN)) begin
                model_err();
                m_in = 1'b0;
            end
        end else if (m_pos == 6 + m_len0) begin
            m_t0_bad = (d[15:4] != 12'hAAA);
            if (m_t0_bad) model_err();
        end else if (m_pos == 7 + m_len0) begin
            m_in = 1'b0;
            if (!m_t0_bad) m_frame = m_frame + 16'd1;
        end
        m_pos++;
    endfunction

    task automatic compare();
        check("out_valid", 32'(OUT_VALID), 32'(mq.size() > 0));
        if (mq.size() > 0) check("out_data", OUT_DATA, mq[0]);
        check("frame_cnt", 32'(FRAME_CNT), 32'(m_frame));
        check("err_cnt", 32'(ERR_CNT), 32'(m_err));
        check("lost_cnt", 32'(LOST_CNT), 32'(m_lost));
        check("busy", 32'(BUSY), 32'(m_in));
    endtask

    // Called at a falling edge; drives inputs, advances one cycle, compares at the next falling edge.
    task automatic step(input bit w, input bit fs, input logic [15:0] d, input bit rdy);
        WRITE = w; FRAME_START = fs; DATA = d; OUT_READY = rdy;
        @(posedge CLK_RX);
        model_apply(w, fs, d, rdy);
        @(negedge CLK_RX);
        compare();
    endtask

    task automatic do_reset();
        WRITE = 0; FRAME_START = 0; OUT_READY = 0;
        RST_N = 1'b0;
        model_reset();
        @(negedge CLK_RX);
        @(negedge CLK_RX);
        RST_N = 1'b1;
    endtask

    task automatic send_header(input logic [15:0] l0, input logic [15:0] l1, input bit rdy);
        step(1, 1, 16'h5551, rdy);
        step(1, 0, 16'h5552, rdy);
        step(1, 0, 16'h0001, rdy);
        step(1, 0, 16'h0000, rdy);
        step(1, 0, l0, rdy);
        step(1, 0, l1, rdy);
    endtask

    task automatic send_good(input int len, input bit rdy);
        send_header(16'(len), 16'(len), rdy);
        for (int i = 0; i < len; i++) step(1, 0, 16'(16'hD000 + i), rdy);
        step(1, 0, 16'hAAA1, rdy);
        step(1, 0, 16'hAAA2, rdy);
    endtask

    // Drains with OUT_READY=1 until empty, bounded; returns words popped.
    task automatic drain(output int n);
        n = 0;
        for (int i = 0; i < 64; i++) begin
            if (!OUT_VALID) break;
            step(0, 0, 16'h0, 1);
            n++;
        end
        check("drain_empty", 32'(OUT_VALID), 32'd0);
    endtask

    typedef struct {
        bit          fs;
        logic [15:0] d;
        logic [31:0] exp;
    } vec_t;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tv[10];
        int   n;
        logic [15:0] w[$];
        bit   fsq[$];

        tv[0] = '{1, 16'h5551, 32'h2001_5551};
        tv[1] = '{0, 16'h5552, 32'h2000_5552};
        tv[2] = '{0, 16'h0001, 32'h2000_0001};
        tv[3] = '{0, 16'h0000, 32'h2000_0000};
        tv[4] = '{0, 16'h0002, 32'h2000_0002};
        tv[5] = '{0, 16'h0002, 32'h2000_0002};
        tv[6] = '{0, 16'h1234, 32'h2000_1234};
        tv[7] = '{0, 16'h5678, 32'h2000_5678};
        tv[8] = '{0, 16'hAAA1, 32'h2000_AAA1};
        tv[9] = '{0, 16'hAAA2, 32'h2000_AAA2};

        model_reset();
        @(negedge CLK_RX);
        check("rst_valid", 32'(OUT_VALID), 32'd0);
        check("rst_data", OUT_DATA, 32'd0);
        check("rst_frame", 32'(FRAME_CNT), 32'd0);
        check("rst_err", 32'(ERR_CNT), 32'd0);
        check("rst_lost", 32'(LOST_CNT), 32'd0);
        check("rst_busy", 32'(BUSY), 32'd0);
        do_reset();

        // Good frame, LEN=2, table driven
        for (int i = 0; i < 10; i++) begin
            step(1, tv[i].fs, tv[i].d, 1);
            check("t1_word", OUT_DATA, tv[i].exp);
        end
        step(0, 0, 16'h0, 1);
        check("t1_frame", 32'(FRAME_CNT), 32'd1);
        check("t1_err", 32'(ERR_CNT), 32'd0);

        // Length mismatch, stray word discarded, then good zero-length frame
        do_reset();
        send_header(16'd3, 16'd4, 0);
        check("t2_err", 32'(ERR_CNT), 32'd1);
        check("t2_busy", 32'(BUSY), 32'd0);
        step(1, 0, 16'h1234, 0);
        drain(n);
        check("t2_pushed", 32'(n), 32'd6);
        send_good(0, 1);
        check("t2_frame", 32'(FRAME_CNT), 32'd1);

        // Oversize length
        do_reset();
        send_header(16'd577, 16'd577, 1);
        check("t3_err", 32'(ERR_CNT), 32'd1);
        check("t3_busy", 32'(BUSY), 32'd0);
        send_good(0, 1);
        check("t3_frame", 32'(FRAME_CNT), 32'd1);

        // FRAME_START during DAT
        do_reset();
        send_header(16'd4, 16'd4, 1);
        step(1, 0, 16'hD000, 1);
        step(1, 0, 16'hD001, 1);
        step(1, 1, 16'h5553, 1);
        check("t4_h0", OUT_DATA, 32'h2001_5553);
        check("t4_err", 32'(ERR_CNT), 32'd1);
        check("t4_busy", 32'(BUSY), 32'd1);
        step(1, 0, 16'h5554, 1);
        step(1, 0, 16'h0002, 1);
        step(1, 0, 16'h0000, 1);
        step(1, 0, 16'h0001, 1);
        step(1, 0, 16'h0001, 1);
        step(1, 0, 16'hBEEF, 1);
        step(1, 0, 16'hAAA0, 1);
        step(1, 0, 16'hAAA3, 1);
        check("t4_frame", 32'(FRAME_CNT), 32'd1);
        check("t4_err_end", 32'(ERR_CNT), 32'd1);

        // Overflow: 24-word frame into a 16-deep FIFO, then stalled drain
        do_reset();
        send_good(16, 0);
        check("t5_lost", 32'(LOST_CNT), 32'd1);
        check("t5_err", 32'(ERR_CNT), 32'd0);
        check("t5_frame", 32'(FRAME_CNT), 32'd0);
        check("t5_busy", 32'(BUSY), 32'd0);
        n = 0;
        for (int i = 0; i < 200 && OUT_VALID; i++) begin
            bit r;
            r = ($urandom_range(0, 2) == 0);
            if (r) n++;
            step(0, 0, 16'h0, r);
        end
        check("t5_drained", 32'(n), 32'd16);

        // Full FIFO with simultaneous pop and push
        do_reset();
        send_header(16'd20, 16'd20, 0);
        for (int i = 0; i < 10; i++) step(1, 0, 16'(16'hE000 + i), 0);
        check("t5b_full", 32'(mq.size()), 32'(DEPTH));
        step(1, 0, 16'hE00A, 1);
        check("t5b_lost", 32'(LOST_CNT), 32'd0);
        check("t5b_busy", 32'(BUSY), 32'd1);

        // Asynchronous reset mid-DAT
        do_reset();
        send_header(16'd8, 16'd8, 0);
        step(1, 0, 16'hD000, 0);
        #2 RST_N = 1'b0;
        #1;
        check("t6_valid", 32'(OUT_VALID), 32'd0);
        check("t6_data", OUT_DATA, 32'd0);
        check("t6_busy", 32'(BUSY), 32'd0);
        check("t6_err", 32'(ERR_CNT), 32'd0);
        model_reset();
        @(negedge CLK_RX);
        RST_N = 1'b1;
        for (int i = 0; i < 4; i++) step(1, 0, 16'(16'hD001 + i), 1);
        check("t6_ignored", 32'(OUT_VALID), 32'd0);
        send_good(3, 1);
        check("t6_frame", 32'(FRAME_CNT), 32'd1);

        // Saturation of ERR_CNT and LOST_CNT
        do_reset();
        for (int i = 0; i < 260; i++) step(1, 1, 16'h0000, 1);
        check("sat_err", 32'(ERR_CNT), 32'd255);
        for (int i = 0; i < 16 + 260; i++) step(1, 1, 16'h0000, 0);
        check("sat_lost", 32'(LOST_CNT), 32'd255);
        check("sat_err_hold", 32'(ERR_CNT), 32'd255);

        // Randomized frames with corruptions, gaps and backpressure
        do_reset();
        for (int f = 0; f < 300; f++) begin
            int len, mode, rp;
            len  = $urandom_range(0, 6);
            mode = $urandom_range(0, 9);
            rp   = (f % 7 == 3) ? 20 : 75;
            w.delete(); fsq.delete();
            w.push_back((mode == 1) ? 16'h1230 : 16'(16'h5550 + $urandom_range(0, 15)));
            w.push_back(16'($urandom));
            w.push_back(16'($urandom));
            w.push_back(16'($urandom));
            if (mode == 5) begin
                w.push_back(16'(577 + $urandom_range(0, 20)));
                w.push_back(w[4]);
            end else begin
                w.push_back(16'(len));
                w.push_back((mode == 2) ? 16'(len + 1) : 16'(len));
            end
            for (int i = 0; i < len; i++) w.push_back(16'($urandom));
            w.push_back((mode == 3) ? 16'h1231 : 16'(16'hAAA0 + $urandom_range(0, 15)));
            w.push_back(16'(16'hAAA0 + $urandom_range(0, 15)));
            if (mode == 4) begin
                int k;
                k = $urandom_range(1, w.size() - 1);
                while (w.size() > k) void'(w.pop_back());
            end else if (mode == 6) begin
                w.push_back(16'($urandom));
            end
            for (int i = 0; i < w.size(); i++) begin
                repeat ($urandom_range(0, 2))
                    step(0, 1'($urandom_range(0, 1)), 16'($urandom), ($urandom_range(0, 99) < rp));
                step(1, (i == 0), w[i], ($urandom_range(0, 99) < rp));
            end
        end
        drain(n);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
